// File: rtl/uart_reg_bridge_pkg.sv
// Shared state encodings and default protocol codes for the UART register bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_reg_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GET_ADDR = 4'd1,
    ST_GET_DATA = 4'd2,
    ST_BUS_WR   = 4'd3,
    ST_BUS_RD   = 4'd4,
    ST_RD_CAP   = 4'd5,
    ST_TX_SEND  = 4'd6,
    ST_TX_GUARD = 4'd7,
    ST_TX_WAIT  = 4'd8
  } state_t;

  localparam int         DEF_TIMEOUT_CYC = 500000;  // 10 ms at 50 MHz
  localparam logic [7:0] DEF_CMD_WR      = 8'h57;   // 'W'
  localparam logic [7:0] DEF_CMD_RD      = 8'h52;   // 'R'
  localparam logic [7:0] DEF_RSP_ACK     = 8'h4B;   // 'K'
  localparam logic [7:0] DEF_RSP_ERR     = 8'h3F;   // '?'

  // States in which an incoming UART byte may be consumed.
  function automatic logic is_rx_state(input state_t s);
    return (s == ST_IDLE) || (s == ST_GET_ADDR) || (s == ST_GET_DATA);
  endfunction

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Bundles the UART byte interface, local register bus and status lines of the bridge.
// Latency: n/a (wiring only).
// Backpressure: rx_rdy/rx_rdy_clr on receive, tx_busy/tx_wr_en on transmit.
interface uart_reg_bridge_if;
  logic [7:0] rx_dout;
  logic       rx_rdy;
  logic       rx_rdy_clr;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       cmd_err;

  // Bridge side: drives the UART control inputs and the register bus.
  modport master (
    input  rx_dout, rx_rdy, tx_busy, reg_rdata,
    output rx_rdy_clr, tx_din, tx_wr_en, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err
  );

  // UART / register file side.
  modport slave (
    output rx_dout, rx_rdy, tx_busy, reg_rdata,
    input  rx_rdy_clr, tx_din, tx_wr_en, reg_addr, reg_wdata, reg_we, reg_re, busy, cmd_err
  );
endinterface

// File: rtl/uart_gap_timer.sv
// Inter-byte gap timer: counts enabled cycles and flags when the gap limit is hit.
// Latency: expire_o is combinational in the cycle the count equals TIMEOUT_CYC-1.
// Backpressure: none; clear has priority over counting and expiry.
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 500000
) (
  input  logic clk_50m,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int            CW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count while enabled and wrap on expiry.
  always_comb begin
    cnt_d    = cnt_q;
    expire_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        expire_o = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_reg_bridge.sv
// Parses 'W' addr data / 'R' addr commands from UART bytes into 8-bit register accesses.
// Latency: last command byte to tx_wr_en is 2 cycles for a write, 3 for a read (tx idle).
// Backpressure: leaves rx bytes unconsumed while busy; holds the response until tx_busy is low.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter logic [7:0] CMD_WR      = DEF_CMD_WR,
  parameter logic [7:0] CMD_RD      = DEF_CMD_RD,
  parameter logic [7:0] RSP_ACK     = DEF_RSP_ACK,
  parameter logic [7:0] RSP_ERR     = DEF_RSP_ERR
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  uart_reg_bridge_if.master bus
);
  state_t     state_q, state_d;
  logic       wr_q, wr_d;
  logic       guard_q;
  logic       rx_clr_q;
  logic       cmd_err_q, cmd_err_d;
  logic [7:0] tx_din_q, tx_din_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       byte_take;
  logic       gap_state;
  logic       expire;

  // A byte is taken only in a receive state and never in the cycle after a take,
  // because the UART drops rdy one cycle after seeing rdy_clr.
  assign byte_take = bus.rx_rdy && !guard_q && is_rx_state(state_q);
  assign gap_state = (state_q == ST_GET_ADDR) || (state_q == ST_GET_DATA);

  uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .clr_i    (byte_take || !gap_state),
    .en_i     (gap_state),
    .expire_o (expire)
  );

  // State register.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode of the command protocol.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_take) begin
          if (bus.rx_dout == CMD_WR || bus.rx_dout == CMD_RD) state_d = ST_GET_ADDR;
          else                                                state_d = ST_TX_SEND;
        end
      end
      ST_GET_ADDR: begin
        if (expire)         state_d = ST_IDLE;
        else if (byte_take) state_d = wr_q ? ST_GET_DATA : ST_BUS_RD;
      end
      ST_GET_DATA: begin
        if (expire)         state_d = ST_IDLE;
        else if (byte_take) state_d = ST_BUS_WR;
      end
      ST_BUS_WR:   state_d = ST_TX_SEND;
      ST_BUS_RD:   state_d = ST_RD_CAP;
      ST_RD_CAP:   state_d = ST_TX_SEND;
      ST_TX_SEND:  if (!bus.tx_busy) state_d = ST_TX_GUARD;
      ST_TX_GUARD: state_d = ST_TX_WAIT;
      ST_TX_WAIT:  if (!bus.tx_busy) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Output/datapath decode: latch command fields and the response byte.
  always_comb begin
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    tx_din_d  = tx_din_q;
    cmd_err_d = expire;
    case (state_q)
      ST_IDLE: begin
        if (byte_take) begin
          wr_d = (bus.rx_dout == CMD_WR);
          if (bus.rx_dout != CMD_WR && bus.rx_dout != CMD_RD) begin
            tx_din_d  = RSP_ERR;
            cmd_err_d = 1'b1;
          end
        end
      end
      ST_GET_ADDR: if (byte_take) addr_d = bus.rx_dout;
      ST_GET_DATA: if (byte_take) wdata_d = bus.rx_dout;
      ST_BUS_WR:   tx_din_d = RSP_ACK;
      ST_RD_CAP:   tx_din_d = bus.reg_rdata;
      default: ;
    endcase
  end

  // Registered datapath and one-cycle rx acknowledge / error pulses.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_q      <= 1'b0;
      guard_q   <= 1'b0;
      rx_clr_q  <= 1'b0;
      cmd_err_q <= 1'b0;
      tx_din_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      wr_q      <= wr_d;
      guard_q   <= byte_take;
      rx_clr_q  <= byte_take;
      cmd_err_q <= cmd_err_d;
      tx_din_q  <= tx_din_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Strobes decode straight from state so reset clears them immediately.
  assign bus.reg_we     = (state_q == ST_BUS_WR);
  assign bus.reg_re     = (state_q == ST_BUS_RD);
  assign bus.tx_wr_en   = (state_q == ST_TX_SEND) && !bus.tx_busy;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.rx_rdy_clr = rx_clr_q;
  assign bus.cmd_err    = cmd_err_q;
  assign bus.tx_din     = tx_din_q;
  assign bus.reg_addr   = addr_q;
  assign bus.reg_wdata  = wdata_q;
endmodule
